// File: rtl/fsgnj_pkg.sv
// fsgnj_pkg: op encodings, canonical NaN, NaN-box mask and sign-selection helper for fsgnj_pipe
package fsgnj_pkg;
    localparam logic [1:0] OP_SGNJ = 2'b00;
    localparam logic [1:0] OP_SGNJN = 2'b01;
    localparam logic [1:0] OP_SGNJX = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [31:0] CANON_NAN_S = 32'h7FC00000;
    localparam logic [63:0] NANBOX_MASK = 64'hFFFFFFFF_00000000;

    function automatic logic inj_sign(logic [1:0] op, logic s1, logic s2);
        return (op == OP_SGNJX) ? s1 ^ s2 : s2 ^ (op == OP_SGNJN);
    endfunction
endpackage

// File: rtl/fsgnj_if.sv
// fsgnj_if: request/result handshake bundle for fsgnj_pipe
interface fsgnj_if #(parameter int FLEN = 32);
    logic in_valid;
    logic in_ready;
    logic [FLEN-1:0] rs1;
    logic [FLEN-1:0] rs2;
    logic [1:0] op;
    logic fmt;
    logic out_valid;
    logic out_ready;
    logic [FLEN-1:0] out_data;
    logic out_err;

    modport master (output in_valid, rs1, rs2, op, fmt, out_ready,
                    input in_ready, out_valid, out_data, out_err);
    modport slave (input in_valid, rs1, rs2, op, fmt, out_ready,
                   output in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/fsgnj_stage.sv
// fsgnj_stage: one elastic register slice holding valid, data and err
module fsgnj_stage #(parameter int W = 32) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err
);
    assign in_ready = !out_valid || out_ready;

    // load when empty or draining; EN low freezes the slice
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_err <= 1'b0;
        end else if (EN && in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_err <= in_err;
            end
        end
    end
endmodule

// File: rtl/fsgnj_pipe.sv
// fsgnj_pipe: pipelined FSGNJ/FSGNJN/FSGNJX unit; FSGNJ_NANBOX_EN adds single-precision NaN-boxing at FLEN=64
module fsgnj_pipe import fsgnj_pkg::*; #(
    parameter int FLEN = 32,
    parameter int STAGES = 1
) (
    input logic CLK,
    input logic RST,
    input logic EN,
    fsgnj_if.slave bus
);
    logic illegal;
    logic [FLEN-1:0] flat;
    logic [FLEN-1:0] res;
    logic [FLEN-1:0] unused_bits;

    assign illegal = bus.op == OP_ILL;
    assign flat = {inj_sign(bus.op, bus.rs1[FLEN-1], bus.rs2[FLEN-1]), bus.rs1[FLEN-2:0]};
    assign unused_bits = {bus.fmt, bus.rs2[FLEN-2:0]};

`ifdef FSGNJ_NANBOX_EN
    if (FLEN == 64) begin : g_box
        logic [31:0] a;
        logic sb;
        // single ops unbox each operand (improper boxes become canonical NaN) and rebox the result
        always_comb begin
            a = ((bus.rs1 & NANBOX_MASK) == NANBOX_MASK) ? bus.rs1[31:0] : CANON_NAN_S;
            sb = ((bus.rs2 & NANBOX_MASK) == NANBOX_MASK) ? bus.rs2[31] : CANON_NAN_S[31];
            res = illegal ? '0 : bus.fmt ? flat : NANBOX_MASK | {32'b0, inj_sign(bus.op, a[31], sb), a[30:0]};
        end
    end else begin : g_flat
        assign res = illegal ? '0 : flat;
    end
`else
    assign res = illegal ? '0 : flat;
`endif

    logic v [STAGES+1];
    logic r [STAGES+1];
    logic e [STAGES+1];
    logic [FLEN-1:0] d [STAGES+1];

    assign v[0] = bus.in_valid;
    assign d[0] = res;
    assign e[0] = illegal;
    assign r[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fsgnj_stage #(.W(FLEN)) u_stage (
            .CLK(CLK), .RST(RST), .EN(EN),
            .in_valid(v[k]), .in_ready(r[k]), .in_data(d[k]), .in_err(e[k]),
            .out_valid(v[k+1]), .out_ready(r[k+1]), .out_data(d[k+1]), .out_err(e[k+1])
        );
    end

    assign bus.in_ready = EN && r[0];
    assign bus.out_valid = EN && v[STAGES];
    assign bus.out_data = d[STAGES];
    assign bus.out_err = e[STAGES];
endmodule

// File: doc/fsgnj_pipe.md
# fsgnj_pipe

Parametrised, pipelined floating-point sign-injection unit for the Floating ALU, covering FSGNJ, FSGNJN and FSGNJX in one block. It selects the operation at run time, supports FLEN of 32 or 64, and uses an elastic valid/ready pipeline of configurable depth. It sits behind the FP issue stage and beside the other Floating ALU units, and writes to the FP writeback arbiter.

## Interface
- FLEN, 32: operand and result width; legal values 32 and 64.
- STAGES, 1: pipeline register slices; legal range 1..3.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  unit enable; low freezes the pipeline.
- in_valid  in  1  request valid.
- in_ready  out  1  unit accepts a request this cycle.
- rs1  in  FLEN  magnitude source.
- rs2  in  FLEN  sign source.
- op  in  2  operation: 00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 illegal.
- fmt  in  1  0 single, 1 double; used only when NaN-boxing is compiled in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  FLEN  result.
- out_err  out  1  the result comes from an illegal op.

## Operation
- Sign bit s is set by op:
  - FSGNJ: s = rs2[FLEN-1].
  - FSGNJN: s = ~rs2[FLEN-1].
  - FSGNJX: s = rs1[FLEN-1] ^ rs2[FLEN-1].
- Result = {s, rs1[FLEN-2:0]}.
- No exception flags are raised. NaN payloads pass through untouched.
- Illegal op (11): out_data = 0 and out_err = 1, delivered in order like any other request.
- A transfer happens when valid and ready are both high in the same cycle.
- Each stage holds valid, data and err.
- A stage loads when it is empty or when its contents move downstream in the same cycle: stage_ready = !valid_k || ready_{k+1}.
- in_ready = EN && stage_ready of stage 0.
- out_valid = EN && valid of the last stage. out_data and out_err come from the last stage.
- EN low:
  - no stage loads or drains, and all contents are kept;
  - in_ready = 0 and out_valid = 0;
  - when EN returns high, operation resumes with no loss or duplication.

## Timing
- Reset, at the first rising CLK edge with RST high:
  - all stage valid, data and err bits clear to 0;
  - so out_valid = 0, out_data = 0, out_err = 0;
  - in_ready = EN after reset.
- Reset has priority over EN and over any handshake.
- Reset during operation discards every in-flight request. No output is produced for those requests.
- Latency: STAGES cycles from the input handshake to out_valid, with out_ready held high.
- Throughput: one result per cycle.
- With out_ready low:
  - out_data and out_err hold stable while out_valid is high;
  - stages fill from the back;
  - in_ready falls only after all STAGES slots hold requests.
- Accepting an input and emitting an output in the same cycle with a full pipeline is legal, and occupancy does not change.
- There is no combinational path from rs1, rs2 or op to the outputs.

## Configuration
- FSGNJ_NANBOX_EN, meaningful only with FLEN=64.
- Defined:
  - fmt=0 operates on bits [31:0].
  - An operand whose [63:32] is not all ones is replaced by canonical NaN 0x7FC00000 before sign injection.
  - The result is {32'hFFFFFFFF, 32-bit result}.
  - fmt=1 uses the full 64 bits.
- Undefined:
  - fmt is ignored and every op uses all FLEN bits.
  - The fmt port still exists.

## Structure
- Package fsgnj_pkg holds:
  - the op encoding constants OP_SGNJ, OP_SGNJN, OP_SGNJX;
  - the canonical NaN constant CANON_NAN_S = 32'h7FC00000;
  - the NaN-box mask.
- Sub-module fsgnj_stage: one elastic register slice with valid, data and err. The slice is instantiated STAGES times in a generate loop. The sign logic stays in the top, ahead of stage 0.

## Test plan
- FLEN=32, STAGES=1, op=00, rs1=0x40866666 (4.2), rs2=0xBF000000 (-0.5) -> out_data=0xC0866666, out_valid one cycle after the handshake.
- Same operands, op=01 -> 0x40866666. Then rs1=0xC0CCCCCC (-6.4), rs2=0xBF000000, op=10 -> 0x40CCCCCC.
- op=11 with any operands -> out_data=0, out_err=1; the following legal request returns out_err=0, in order.
- STAGES=3, out_ready held low, 5 back-to-back requests -> in_ready falls after 3 accepts. Releasing out_ready drains all results in order with no loss.
- EN dropped for 4 cycles mid-stream, and separately RST pulsed mid-stream:
  - EN case -> in_ready=0 and out_valid=0 for 4 cycles, then results resume intact;
  - RST case -> all outputs 0 next cycle and in-flight requests discarded.
- FLEN=64 with FSGNJ_NANBOX_EN, fmt=0:
  - rs1=0xFFFFFFFF_40866666, rs2=0xFFFFFFFF_BF000000, op=00 -> 0xFFFFFFFF_C0866666;
  - rs1=0x00000000_40866666 -> 0xFFFFFFFF_FFC00000.
